dma_copy_engine: RTL
====================

Name: dma_copy_engine

Overview:
- Copy-job sequencer sitting directly in front of the DMA/HBM channel model.
- Accepts one copy job (source address, destination address, byte length) at a time and splits it into bursts of at most MAX_BURST bytes.
- For each burst, issues a read cmd and a write cmd, forwards the read data stream into the write data stream, and counts write completions (back_valid).
- Reports job completion on a done handshake.

Parameters:
- WIDTH, 512, data beat width in bits; beat size B = WIDTH/8 bytes.
- MAX_BURST, 4096, maximum burst size in bytes; power of two and a multiple of B.
- MAX_OUTSTANDING, 8, maximum write bursts issued but not yet acknowledged on back.

Ports:
- clock  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- job_valid  in  1  job request valid.
- job_ready  out  1  engine can accept a job.
- job_src  in  64  source byte address.
- job_dst  in  64  destination byte address.
- job_len  in  32  length in bytes.
- done_valid  out  1  job finished.
- done_ready  in  1  done accepted.
- done_bursts  out  32  number of bursts the finished job used.
- busy  out  1  state != IDLE.
- read_cmd_valid/ready/address/length  out/in/out/out  1/1/64/32  read command.
- write_cmd_valid/ready/address/length  out/in/out/out  1/1/64/32  write command.
- read_data_valid/ready/data/keep/last  in/out/in/in/in  1/1/WIDTH/WIDTH/8/1  read data stream.
- write_data_valid/ready/data/keep/last  out/in/out/out/out  1/1/WIDTH/WIDTH/8/1  write data stream.
- back_valid  in  1  write completion.
- back_ready  out  1  completion accept.

Behaviour:
- Reset (reset=0, async): state IDLE; all valids 0; addresses, lengths and data 0; done_bursts 0; outstanding count 0; data buffer empty. job_ready=1 and back_ready=1 once reset is released.
- Alignment: low log2(B) bits of job_src, job_dst and job_len are ignored (truncated). Lengths are handled in beats internally.
- States:
  - IDLE: job_ready=1. On job_valid & job_ready, latch src, dst and len, clear the burst counter, then go to ISSUE, or to DONE if the truncated len is 0.
  - ISSUE: current burst length L = min(remaining, MAX_BURST). Assert read_cmd and write_cmd (address = current src/dst, length = L) together. Each deasserts independently once it has handshaked; the burst is committed when both have fired. Write_cmd may only be asserted while outstanding < MAX_OUTSTANDING; read_cmd is gated identically. On commit: src += L, dst += L, remaining -= L, bursts += 1, outstanding += 1. When remaining reaches 0, go to DRAIN.
  - DRAIN: wait until all beats of the job have been forwarded and outstanding == 0, then go to DONE.
  - DONE: done_valid=1, done_bursts held stable. On done_ready, go to IDLE. done_valid must not drop before done_ready.
- Data path:
  - 2-entry registered FIFO from read_data to write_data; read_data_ready = FIFO not full.
  - Min latency 1 cycle from read beat accepted to write_data_valid.
  - Full throughput (1 beat/cycle) when write_data_ready is held at 1.
- Stream sideband:
  - write_data_keep is all-ones.
  - read_data_keep and read_data_last are ignored.
  - write_data_last is generated internally: a per-burst beat down-counter, loaded from a small burst-length queue (depth MAX_OUTSTANDING) written at each commit, asserts last on the final beat of each burst.
- Outstanding counter:
  - Increments on commit, decrements on back_valid & back_ready.
  - Simultaneous commit and back leaves it unchanged.
  - back_valid arriving while the counter is 0 is ignored and does not underflow.
- job_valid is ignored outside IDLE.
- Reset mid-job:
  - Immediate abort to IDLE.
  - Buffered data is discarded.
  - Pending cmds are dropped (valids low).

Test Plan:
- WIDTH=512, MAX_BURST=4096. Job src=0x0, dst=0x10000, len=0x100 -> one read cmd (0x0, 0x100) and one write cmd (0x10000, 0x100); 4 write beats with data equal to the read data, last on beat 4; after one back pulse, done_valid=1 with done_bursts=1.
- len=0x2040, src=0x1000, dst=0x80000 -> read cmds (0x1000,0x1000), (0x2000,0x1000), (0x3000,0x40); write cmds at 0x80000, 0x81000, 0x82000; write_data_last on beats 64, 128, 129; done_bursts=3 after 3 back pulses.
- MAX_OUTSTANDING=2, len=0x4000, back_valid held 0 -> exactly 2 write cmds issued, then the engine stalls in ISSUE; one back pulse -> the third pair issues within 2 cycles.
- write_data_ready toggled 1010... for len=0x1000 -> all 64 beats delivered in order with no loss or duplication; read_data_ready=0 whenever 2 beats are buffered.
- job_len=0x3F (truncates to 0) -> no cmds issued; done_valid=1 with done_bursts=0 the cycle after job accept; done_ready held 0 for 5 cycles -> done_valid stays 1.
- Assert reset during the 20th beat of a 64-beat job -> all valids 0 and busy=0 immediately; after release, job_ready=1 and a new job runs correctly.

Source files
------------

// File: rtl/dma_copy_engine.sv
// dma_copy_engine: splits copy jobs into bursts, issues paired read/write cmds, forwards read data to write data, counts write completions
// Ports:
//   clk_i, rst_ni                       clock, asynchronous active-low reset
//   job_*                               job request (src/dst byte address, byte length)
//   done_*                              job completion handshake with burst count
//   busy_o                              engine not idle
//   read_cmd_*, write_cmd_*             per-burst commands (address, byte length)
//   read_data_*, write_data_*           beat streams, joined by a 2-entry FIFO
//   back_valid_i, back_ready_o          write burst completions
module dma_copy_engine #(
  parameter int WIDTH           = 512,
  parameter int MAX_BURST       = 4096,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               job_valid_i,
  output logic               job_ready_o,
  input  logic [63:0]        job_src_i,
  input  logic [63:0]        job_dst_i,
  input  logic [31:0]        job_len_i,
  output logic               done_valid_o,
  input  logic               done_ready_i,
  output logic [31:0]        done_bursts_o,
  output logic               busy_o,
  output logic               read_cmd_valid_o,
  input  logic               read_cmd_ready_i,
  output logic [63:0]        read_cmd_address_o,
  output logic [31:0]        read_cmd_length_o,
  output logic               write_cmd_valid_o,
  input  logic               write_cmd_ready_i,
  output logic [63:0]        write_cmd_address_o,
  output logic [31:0]        write_cmd_length_o,
  input  logic               read_data_valid_i,
  output logic               read_data_ready_o,
  input  logic [WIDTH-1:0]   read_data_i,
  input  logic [WIDTH/8-1:0] read_data_keep_i,
  input  logic               read_data_last_i,
  output logic               write_data_valid_o,
  input  logic               write_data_ready_i,
  output logic [WIDTH-1:0]   write_data_o,
  output logic [WIDTH/8-1:0] write_data_keep_o,
  output logic               write_data_last_o,
  input  logic               back_valid_i,
  output logic               back_ready_o
);
  localparam int B   = WIDTH / 8;
  localparam int BW  = $clog2(B);
  localparam int LW  = 32 - BW;
  localparam int MB  = MAX_BURST / B;
  localparam int MBW = $clog2(MB) + 1;
  localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int QW  = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

  state_e         state_q, state_d;
  logic [63:0]    src_q, src_d, dst_q, dst_d;
  logic [LW-1:0]  rem_q, rem_d, fwd_q, fwd_d, burst;
  logic [31:0]    bursts_q, bursts_d, blen;
  logic [OW-1:0]  out_q, out_d, bcnt_q;
  logic           rd_fired_q, rd_fired_d, wr_fired_q, wr_fired_d;
  logic [WIDTH-1:0] fifo_q [2];
  logic           fwp_q, frp_q;
  logic [1:0]     fcnt_q;
  logic [MBW-1:0] bq_q [MAX_OUTSTANDING];
  logic [QW-1:0]  bwp_q, brp_q;
  logic [MBW-1:0] beat_q;
  logic           can_issue, rd_fire, wr_fire, commit, back_hs, push, pop, last, unused;

  function automatic logic [QW-1:0] nxt(input logic [QW-1:0] p);
    return p == QW'(MAX_OUTSTANDING - 1) ? '0 : p + QW'(1);
  endfunction

  assign unused = ^{read_data_keep_i, read_data_last_i, job_src_i[BW-1:0], job_dst_i[BW-1:0], job_len_i[BW-1:0]};

  // lengths are tracked in beats; byte fields are the beat count shifted up
  assign burst = rem_q < LW'(MB) ? rem_q : LW'(MB);
  assign blen  = {burst, {BW{1'b0}}};
  // the burst-length queue never holds more entries than outstanding bursts, but guard it anyway
  assign can_issue = (out_q < OW'(MAX_OUTSTANDING)) && (bcnt_q < OW'(MAX_OUTSTANDING));
  assign read_cmd_valid_o  = state_q == ISSUE && !rd_fired_q && can_issue;
  assign write_cmd_valid_o = state_q == ISSUE && !wr_fired_q && can_issue;
  assign rd_fire = read_cmd_valid_o && read_cmd_ready_i;
  assign wr_fire = write_cmd_valid_o && write_cmd_ready_i;
  assign commit  = (rd_fired_q || rd_fire) && (wr_fired_q || wr_fire);
  assign back_hs = back_valid_i && out_q != '0;
  assign read_cmd_address_o  = src_q;
  assign write_cmd_address_o = dst_q;
  assign read_cmd_length_o   = blen;
  assign write_cmd_length_o  = blen;
  assign job_ready_o   = state_q == IDLE;
  assign busy_o        = state_q != IDLE;
  assign done_valid_o  = state_q == DONE;
  assign done_bursts_o = bursts_q;
  assign back_ready_o  = 1'b1;
  assign read_data_ready_o = fcnt_q != 2'd2;
  assign push = read_data_valid_i && read_data_ready_o;
  // data may arrive before its burst commits; hold it until the burst length is known
  assign write_data_valid_o = fcnt_q != 2'd0 && bcnt_q != '0;
  assign pop  = write_data_valid_o && write_data_ready_i;
  assign last = bq_q[brp_q] == beat_q + MBW'(1);
  assign write_data_o      = fifo_q[frp_q];
  assign write_data_keep_o = '1;
  assign write_data_last_o = write_data_valid_o && last;

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    rem_d      = rem_q;
    fwd_d      = fwd_q - LW'(pop);
    bursts_d   = bursts_q;
    out_d      = out_q + OW'(commit) - OW'(back_hs);
    rd_fired_d = (rd_fired_q || rd_fire) && !commit;
    wr_fired_d = (wr_fired_q || wr_fire) && !commit;
    case (state_q)
      IDLE: if (job_valid_i) begin
        src_d    = {job_src_i[63:BW], {BW{1'b0}}};
        dst_d    = {job_dst_i[63:BW], {BW{1'b0}}};
        rem_d    = job_len_i[31:BW];
        fwd_d    = job_len_i[31:BW];
        bursts_d = '0;
        state_d  = job_len_i[31:BW] == '0 ? DONE : ISSUE;
      end
      ISSUE: if (commit) begin
        src_d    = src_q + 64'(blen);
        dst_d    = dst_q + 64'(blen);
        rem_d    = rem_q - burst;
        bursts_d = bursts_q + 32'd1;
        state_d  = rem_q == burst ? DRAIN : ISSUE;
      end
      DRAIN: state_d = fwd_q == '0 && out_q == '0 ? DONE : DRAIN;
      default: state_d = done_ready_i ? IDLE : DONE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      rem_q      <= '0;
      fwd_q      <= '0;
      bursts_q   <= '0;
      out_q      <= '0;
      rd_fired_q <= 1'b0;
      wr_fired_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      rem_q      <= rem_d;
      fwd_q      <= fwd_d;
      bursts_q   <= bursts_d;
      out_q      <= out_d;
      rd_fired_q <= rd_fired_d;
      wr_fired_q <= wr_fired_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 2; i++) fifo_q[i] <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) bq_q[i] <= '0;
      fwp_q  <= 1'b0;
      frp_q  <= 1'b0;
      fcnt_q <= '0;
      bwp_q  <= '0;
      brp_q  <= '0;
      bcnt_q <= '0;
      beat_q <= '0;
    end else begin
      if (push) begin
        fifo_q[fwp_q] <= read_data_i;
        fwp_q         <= ~fwp_q;
      end
      if (pop) frp_q <= ~frp_q;
      fcnt_q <= fcnt_q + 2'(push) - 2'(pop);
      if (commit) begin
        bq_q[bwp_q] <= MBW'(burst);
        bwp_q       <= nxt(bwp_q);
      end
      if (pop) begin
        beat_q <= last ? '0 : beat_q + MBW'(1);
        if (last) brp_q <= nxt(brp_q);
      end
      bcnt_q <= bcnt_q + OW'(commit) - OW'(pop && last);
    end
  end
endmodule
